// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave to APB master bridge, four equal APB slave regions above SLV_BASE.
// Latency: read data phase 2 cycles, write data phase 3 cycles (WWAIT captures Hwdata first).
// Backpressure: Hreadyout is low during WWAIT/SETUP (and ERR1); AHB inputs are ignored while it is low.
//
// Optional feature: define BRIDGE_ERR_RESP_EN to answer unmapped NONSEQ/SEQ transfers with a
// two-cycle ERROR response (ERR1 then ERR2). Without it, unmapped transfers are dropped with OKAY.
//
// Ports:
//   Hclk, Hreset                 clock (rising edge) and synchronous active-high reset
//   Htrans, Hsize, Hreadyin,
//   Hwrite, Haddr, Hwdata        AHB-Lite slave request side (Hsize accepted but not forwarded)
//   Hrdata, Hresp, Hreadyout     AHB-Lite slave response side
//   Pselx, Pwrite, Penable,
//   Paddr, Pwdata                APB master request side (all registered)
//   Prdata                       APB read data, passed straight through to Hrdata in RACC
module ahb_apb_bridge #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] SLV_BASE    = ADDR_WIDTH'(32'h8000_0000),
    parameter int                    REGION_BITS = 26
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic [1:0]            Htrans,
    input  logic [2:0]            Hsize,
    input  logic                  Hreadyin,
    input  logic                  Hwrite,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic [1:0]            Hresp,
    output logic                  Hreadyout,
    output logic [3:0]            Pselx,
    output logic                  Pwrite,
    output logic                  Penable,
    output logic [ADDR_WIDTH-1:0] Paddr,
    output logic [DATA_WIDTH-1:0] Pwdata,
    input  logic [DATA_WIDTH-1:0] Prdata
);

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
`ifdef BRIDGE_ERR_RESP_EN
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
`endif

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        RSETUP,
        RACC,
        WSETUP,
`ifdef BRIDGE_ERR_RESP_EN
        ERR1,
        ERR2,
`endif
        WACC
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              pselx_q, pselx_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;

    // Transfer size is accepted as-is; only word transfers exist on this bus.
    logic unused_hsize;
    assign unused_hsize = ^Hsize;

    // ------------------------------------------------------------------
    // Address decode. The window is [SLV_BASE, SLV_BASE + 4 regions); the
    // above_base term stops a low address from wrapping into the window
    // through the subtraction.
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] offset;
    logic                  above_base;
    logic                  in_window;
    logic                  xfer_act;
    logic                  mapped;
    logic                  valid;
    logic [1:0]            dec_idx;

    assign offset     = Haddr - SLV_BASE;
    assign above_base = (Haddr >= SLV_BASE);
    assign in_window  = ((offset >> (REGION_BITS + 2)) == '0);
    assign dec_idx    = offset[REGION_BITS+1:REGION_BITS];
    assign xfer_act   = Hreadyin && ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));
    assign mapped     = above_base && in_window;
    assign valid      = xfer_act && mapped;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // ------------------------------------------------------------------
    // State register and registered APB outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q   <= IDLE;
            sel_q     <= 2'b00;
            addr_q    <= '0;
            pselx_q   <= 4'b0000;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            pselx_q   <= pselx_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and next APB register values. The APB outputs are computed
    // for the state being entered so that they are registered, not decoded.
    // Transfer direction is carried by the state itself (read vs write path),
    // so only the address and slave index are latched on acceptance.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        pselx_d   = pselx_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;

        case (state_q)
            WWAIT: begin
                // Write data is only valid in the AHB data phase, one cycle
                // after the address, hence the extra state before SETUP.
                pwdata_d  = Hwdata;
                pselx_d   = onehot(sel_q);
                pwrite_d  = 1'b1;
                paddr_d   = addr_q;
                penable_d = 1'b0;
                state_d   = WSETUP;
            end

            RSETUP: begin
                penable_d = 1'b1;
                state_d   = RACC;
            end

            WSETUP: begin
                penable_d = 1'b1;
                state_d   = WACC;
            end

`ifdef BRIDGE_ERR_RESP_EN
            ERR1: begin
                state_d = ERR2;
            end
`endif

            // IDLE, RACC, WACC (and ERR2) are the cycles where Hreadyout is
            // high, so the AHB address phase is sampled here. Unused
            // encodings fall back through the same path to IDLE.
            default: begin
                state_d   = IDLE;
                pselx_d   = 4'b0000;
                penable_d = 1'b0;
                if (valid && !Hwrite) begin
                    // Reads go straight to SETUP: no idle APB cycle between
                    // back-to-back reads.
                    state_d  = RSETUP;
                    sel_d    = dec_idx;
                    addr_d   = Haddr;
                    pselx_d  = onehot(dec_idx);
                    pwrite_d = 1'b0;
                    paddr_d  = Haddr;
                end else if (valid && Hwrite) begin
                    // APB stays idle (Paddr/Pwrite hold) until data arrives.
                    state_d = WWAIT;
                    sel_d   = dec_idx;
                    addr_d  = Haddr;
                end
`ifdef BRIDGE_ERR_RESP_EN
                else if (xfer_act) begin
                    state_d = ERR1;
                end
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // AHB response, decoded from the current state
    // ------------------------------------------------------------------
    logic       hready_c;
    logic [1:0] hresp_c;

    always_comb begin
        hready_c = 1'b0;
        hresp_c  = HRESP_OKAY;
        case (state_q)
            IDLE, RACC, WACC: hready_c = 1'b1;
`ifdef BRIDGE_ERR_RESP_EN
            // Two-cycle ERROR: the master sees ERROR with ready low first so
            // it can cancel the following transfer.
            ERR1: hresp_c = HRESP_ERROR;
            ERR2: begin
                hready_c = 1'b1;
                hresp_c  = HRESP_ERROR;
            end
`endif
            default: hready_c = 1'b0;
        endcase
    end

    assign Hreadyout = hready_c;
    assign Hresp     = hresp_c;
    assign Hrdata    = (state_q == RACC) ? Prdata : '0;

    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: directed and randomized checks of ahb_apb_bridge.
// Inputs are driven 1 time unit after the rising edge and outputs sampled there too;
// a pipelined AHB driver is checked against a transaction-level model of the bridge.
module tb_ahb_apb_bridge;

    localparam longint BASE = 64'h8000_0000;
    localparam longint RSZ  = 64'h1 << 26;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic        Hreadyin;
    logic        Hwrite;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        Hreadyout;
    logic [3:0]  Pselx;
    logic        Pwrite;
    logic        Penable;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    int total = 0;
    int bad   = 0;

    always #5 Hclk = ~Hclk;

    ahb_apb_bridge dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Htrans    (Htrans),
        .Hsize     (Hsize),
        .Hreadyin  (Hreadyin),
        .Hwrite    (Hwrite),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hrdata    (Hrdata),
        .Hresp     (Hresp),
        .Hreadyout (Hreadyout),
        .Pselx     (Pselx),
        .Pwrite    (Pwrite),
        .Penable   (Penable),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata)
    );

    // ---------------- reference model helpers ----------------
    function automatic bit f_mapped(input logic [31:0] a);
        longint x;
        x = longint'(a);
        return (x >= BASE) && (x < BASE + 4 * RSZ);
    endfunction

    function automatic logic [3:0] f_sel(input logic [31:0] a);
        longint x;
        int     k;
        x = longint'(a);
        k = int'((x - BASE) / RSZ);
        return 4'(1 << k);
    endfunction

    // APB slave: read data is a fixed scramble of the address unless forced.
    function automatic logic [31:0] f_prd(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    logic        prd_force = 1'b0;
    logic [31:0] prd_val   = 32'h0;
    assign Prdata = prd_force ? prd_val : f_prd(Paddr);

    // ---------------- APB monitor ----------------
    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } apb_rec_t;

    apb_rec_t   apb_q[$];
    logic [3:0] hist[$];
    bit         hist_en = 1'b0;

    always @(negedge Hclk) begin
        apb_rec_t m;
        if (Penable === 1'b1 && Pselx !== 4'b0000) begin
            m.sel   = Pselx;
            m.addr  = Paddr;
            m.wr    = Pwrite;
            m.wdata = Pwdata;
            apb_q.push_back(m);
        end
        if (hist_en) hist.push_back(Pselx);
    end

    // ---------------- drive helpers ----------------
    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic rin);
        Htrans   = tr;
        Haddr    = a;
        Hwrite   = wr;
        Hreadyin = rin;
        Hsize    = 3'b010;
    endtask

    task automatic idle_drive();
        drive(2'b00, 32'h0, 1'b0, 1'b1);
    endtask

    // ---------------- sequence driver + model ----------------
    logic [31:0] sq_addr[$];
    logic [1:0]  sq_trans[$];
    logic        sq_wr[$];
    logic        sq_rdyin[$];
    logic [31:0] sq_wdata[$];

    task automatic add(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic rin, input logic [31:0] wd);
        sq_trans.push_back(tr);
        sq_addr.push_back(a);
        sq_wr.push_back(wr);
        sq_rdyin.push_back(rin);
        sq_wdata.push_back(wd);
    endtask

    task automatic run_seq(input string tag);
        int          n, idx, dph, dcyc, guard;
        logic        rdy;
        bit          act, mp;
        int          e_lat[$];
        logic [1:0]  e_resp[$];
        logic [31:0] e_rd[$];
        apb_rec_t    e_apb[$];
        apb_rec_t    r, g;

        n = sq_addr.size();
        for (int i = 0; i < n; i++) begin
            act = sq_rdyin[i] && (sq_trans[i] >= 2'd2);
            mp  = f_mapped(sq_addr[i]);
            e_lat.push_back(1);
            e_resp.push_back(2'b00);
            e_rd.push_back(32'h0);
            if (act && mp) begin
                r.sel   = f_sel(sq_addr[i]);
                r.addr  = sq_addr[i];
                r.wr    = sq_wr[i];
                r.wdata = sq_wr[i] ? sq_wdata[i] : 32'h0;
                e_apb.push_back(r);
                e_lat[i] = sq_wr[i] ? 3 : 2;
                if (!sq_wr[i]) e_rd[i] = f_prd(sq_addr[i]);
            end else if (act) begin
`ifdef BRIDGE_ERR_RESP_EN
                e_lat[i]  = 2;
                e_resp[i] = 2'b01;
`endif
            end
        end

        apb_q.delete();
        idx = 0; dph = -1; dcyc = 0; guard = 0;
        if (n > 0) drive(sq_trans[0], sq_addr[0], sq_wr[0], sq_rdyin[0]);
        while ((idx < n || dph >= 0) && guard < 8 * n + 20) begin
            rdy = Hreadyout;
            if (dph >= 0) begin
                total++;
                if (Hresp !== e_resp[dph]) begin
                    bad++;
                    $display("FAIL %s_resp[%0d] got=%b exp=%b", tag, dph, Hresp, e_resp[dph]);
                end
                if (rdy === 1'b1) begin
                    total++;
                    if (dcyc != e_lat[dph]) begin
                        bad++;
                        $display("FAIL %s_latency[%0d] got=%0d exp=%0d", tag, dph, dcyc, e_lat[dph]);
                    end
                    total++;
                    if (Hrdata !== e_rd[dph]) begin
                        bad++;
                        $display("FAIL %s_hrdata[%0d] got=%h exp=%h", tag, dph, Hrdata, e_rd[dph]);
                    end
                end
            end
            tick();
            guard++;
            if (rdy === 1'b1) begin
                if (idx < n) begin
                    dph    = idx;
                    Hwdata = sq_wdata[idx];
                    idx++;
                end else begin
                    dph = -1;
                end
                if (idx < n) drive(sq_trans[idx], sq_addr[idx], sq_wr[idx], sq_rdyin[idx]);
                else idle_drive();
                dcyc = 1;
            end else begin
                dcyc++;
            end
        end
        total++;
        if (idx < n || dph >= 0) begin
            bad++;
            $display("FAIL %s_timeout got=idx%0d exp=idx%0d", tag, idx, n);
        end

        total++;
        if (apb_q.size() != e_apb.size()) begin
            bad++;
            $display("FAIL %s_apb_count got=%0d exp=%0d", tag, apb_q.size(), e_apb.size());
        end else begin
            foreach (e_apb[i]) begin
                g = apb_q[i];
                if (!e_apb[i].wr) g.wdata = 32'h0;
                total++;
                if (g !== e_apb[i]) begin
                    bad++;
                    $display("FAIL %s_apb[%0d] got=%h exp=%h", tag, i, g, e_apb[i]);
                end
            end
        end

        sq_addr.delete(); sq_trans.delete(); sq_wr.delete(); sq_rdyin.delete(); sq_wdata.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Hreset = 1'b1;
        Hwdata = 32'h0;
        idle_drive();
        tick(); tick();
        Hreset = 1'b0;
        total++; if (Pselx !== 4'b0000) begin bad++; $display("FAIL rst_pselx got=%b exp=0000", Pselx); end
        total++; if (Penable !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b exp=0", Penable); end
        total++; if (Pwrite !== 1'b0) begin bad++; $display("FAIL rst_pwrite got=%b exp=0", Pwrite); end
        total++; if (Paddr !== 32'h0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", Paddr); end
        total++; if (Pwdata !== 32'h0) begin bad++; $display("FAIL rst_pwdata got=%h exp=0", Pwdata); end
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL rst_hreadyout got=%b exp=1", Hreadyout); end
        total++; if (Hresp !== 2'b00) begin bad++; $display("FAIL rst_hresp got=%b exp=00", Hresp); end
        total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", Hrdata); end

        // Reset while a write sits in WSETUP: the APB access must never happen.
        apb_q.delete();
        drive(2'b10, 32'h8000_0040, 1'b1, 1'b1);
        tick();
        Hwdata = 32'h0BAD_F00D;
        idle_drive();
        tick();
        total++; if (Pselx !== 4'b0001) begin bad++; $display("FAIL rst_wsetup_psel got=%b exp=0001", Pselx); end
        Hreset = 1'b1;
        tick();
        total++; if (Pselx !== 4'b0000) begin bad++; $display("FAIL rst_mid_pselx got=%b exp=0000", Pselx); end
        total++; if (Penable !== 1'b0) begin bad++; $display("FAIL rst_mid_penable got=%b exp=0", Penable); end
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL rst_mid_hreadyout got=%b exp=1", Hreadyout); end
        total++; if (Hresp !== 2'b00) begin bad++; $display("FAIL rst_mid_hresp got=%b exp=00", Hresp); end
        tick();
        Hreset = 1'b0;
        tick();
        total++; if (Penable !== 1'b0) begin bad++; $display("FAIL rst_after_penable got=%b exp=0", Penable); end
        total++; if (apb_q.size() != 0) begin bad++; $display("FAIL rst_apb_count got=%0d exp=0", apb_q.size()); end
    endtask

    task automatic test_single_write();
        apb_q.delete();
        drive(2'b10, 32'h8400_0010, 1'b1, 1'b1);
        tick();                                   // WWAIT
        Hwdata = 32'hDEAD_BEEF;
        idle_drive();
        total++; if (Hreadyout !== 1'b0) begin bad++; $display("FAIL wr_wwait_ready got=%b exp=0", Hreadyout); end
        total++; if (Pselx !== 4'b0000) begin bad++; $display("FAIL wr_wwait_psel got=%b exp=0000", Pselx); end
        tick();                                   // WSETUP
        Hwdata = 32'h0;
        total++; if (Pselx !== 4'b0010) begin bad++; $display("FAIL wr_setup_psel got=%b exp=0010", Pselx); end
        total++; if (Pwrite !== 1'b1) begin bad++; $display("FAIL wr_setup_pwrite got=%b exp=1", Pwrite); end
        total++; if (Paddr !== 32'h8400_0010) begin bad++; $display("FAIL wr_setup_paddr got=%h exp=84000010", Paddr); end
        total++; if (Pwdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_setup_pwdata got=%h exp=deadbeef", Pwdata); end
        total++; if (Penable !== 1'b0) begin bad++; $display("FAIL wr_setup_penable got=%b exp=0", Penable); end
        total++; if (Hreadyout !== 1'b0) begin bad++; $display("FAIL wr_setup_ready got=%b exp=0", Hreadyout); end
        tick();                                   // WACC
        total++; if (Penable !== 1'b1) begin bad++; $display("FAIL wr_acc_penable got=%b exp=1", Penable); end
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL wr_acc_ready got=%b exp=1", Hreadyout); end
        total++; if (Pselx !== 4'b0010) begin bad++; $display("FAIL wr_acc_psel got=%b exp=0010", Pselx); end
        total++; if (Pwdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_acc_pwdata got=%h exp=deadbeef", Pwdata); end
        tick();                                   // IDLE
        total++; if (Pselx !== 4'b0000) begin bad++; $display("FAIL wr_idle_psel got=%b exp=0000", Pselx); end
        total++; if (Paddr !== 32'h8400_0010) begin bad++; $display("FAIL wr_idle_paddr_hold got=%h exp=84000010", Paddr); end
        total++; if (Pwrite !== 1'b1) begin bad++; $display("FAIL wr_idle_pwrite_hold got=%b exp=1", Pwrite); end
    endtask

    task automatic test_single_read();
        prd_force = 1'b1;
        prd_val   = 32'h1234_5678;
        drive(2'b10, 32'h8C00_0004, 1'b0, 1'b1);
        tick();                                   // RSETUP
        idle_drive();
        total++; if (Pselx !== 4'b1000) begin bad++; $display("FAIL rd_setup_psel got=%b exp=1000", Pselx); end
        total++; if (Pwrite !== 1'b0) begin bad++; $display("FAIL rd_setup_pwrite got=%b exp=0", Pwrite); end
        total++; if (Paddr !== 32'h8C00_0004) begin bad++; $display("FAIL rd_setup_paddr got=%h exp=8c000004", Paddr); end
        total++; if (Penable !== 1'b0) begin bad++; $display("FAIL rd_setup_penable got=%b exp=0", Penable); end
        total++; if (Hreadyout !== 1'b0) begin bad++; $display("FAIL rd_setup_ready got=%b exp=0", Hreadyout); end
        total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL rd_setup_hrdata got=%h exp=0", Hrdata); end
        tick();                                   // RACC
        total++; if (Pselx !== 4'b1000) begin bad++; $display("FAIL rd_acc_psel got=%b exp=1000", Pselx); end
        total++; if (Penable !== 1'b1) begin bad++; $display("FAIL rd_acc_penable got=%b exp=1", Penable); end
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL rd_acc_ready got=%b exp=1", Hreadyout); end
        total++; if (Hrdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_acc_hrdata got=%h exp=12345678", Hrdata); end
        tick();                                   // IDLE
        total++; if (Pselx !== 4'b0000) begin bad++; $display("FAIL rd_idle_psel got=%b exp=0000", Pselx); end
        total++; if (Hrdata !== 32'h0) begin bad++; $display("FAIL rd_idle_hrdata got=%h exp=0", Hrdata); end
        prd_force = 1'b0;
    endtask

    task automatic test_back_to_back();
        int         first;
        logic [3:0] ex [5];
        ex = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0000};
        hist.delete();
        hist_en = 1'b1;
        add(2'b10, 32'h8000_0000, 1'b0, 1'b1, 32'h0);
        add(2'b11, 32'h8800_0000, 1'b0, 1'b1, 32'h0);
        run_seq("b2b");
        tick();
        hist_en = 1'b0;
        first = -1;
        foreach (hist[i]) if (first < 0 && hist[i] != 4'b0000) first = i;
        total++;
        if (first < 0 || hist.size() < first + 5) begin
            bad++;
            $display("FAIL b2b_hist_len got=%0d exp>=%0d", hist.size(), first + 5);
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (hist[first+k] !== ex[k]) begin
                    bad++;
                    $display("FAIL b2b_psel[%0d] got=%b exp=%b", k, hist[first+k], ex[k]);
                end
            end
        end
    endtask

    task automatic test_ignored();
        apb_q.delete();
        for (int k = 0; k < 6; k++) begin
            if (k < 2)      drive(2'b01, 32'h8000_0000 + 32'(k * 4), 1'(k), 1'b1);   // BUSY
            else if (k < 4) drive(2'b10, 32'h8400_0000, 1'(k), 1'b0);               // Hreadyin low
            else            drive(2'b00, 32'h8800_0000, 1'(k), 1'b1);               // IDLE
            tick();
            total++; if (Pselx !== 4'b0000) begin bad++; $display("FAIL ign_psel[%0d] got=%b exp=0000", k, Pselx); end
            total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL ign_ready[%0d] got=%b exp=1", k, Hreadyout); end
        end
        idle_drive();
        tick();
        total++; if (apb_q.size() != 0) begin bad++; $display("FAIL ign_apb_count got=%0d exp=0", apb_q.size()); end
    endtask

    task automatic test_unmapped();
        logic [1:0] r1, r2;
        logic       h1;
`ifdef BRIDGE_ERR_RESP_EN
        r1 = 2'b01; h1 = 1'b0; r2 = 2'b01;
`else
        r1 = 2'b00; h1 = 1'b1; r2 = 2'b00;
`endif
        apb_q.delete();
        drive(2'b10, 32'h9000_0000, 1'b1, 1'b1);
        tick();
        Hwdata = 32'hCAFE_0001;
        idle_drive();
        total++; if (Hresp !== r1) begin bad++; $display("FAIL unm_resp1 got=%b exp=%b", Hresp, r1); end
        total++; if (Hreadyout !== h1) begin bad++; $display("FAIL unm_ready1 got=%b exp=%b", Hreadyout, h1); end
        total++; if (Pselx !== 4'b0000) begin bad++; $display("FAIL unm_psel1 got=%b exp=0000", Pselx); end
        tick();
        total++; if (Hresp !== r2) begin bad++; $display("FAIL unm_resp2 got=%b exp=%b", Hresp, r2); end
        total++; if (Hreadyout !== 1'b1) begin bad++; $display("FAIL unm_ready2 got=%b exp=1", Hreadyout); end
        tick();
        total++; if (Hresp !== 2'b00) begin bad++; $display("FAIL unm_resp3 got=%b exp=00", Hresp); end
        total++; if (apb_q.size() != 0) begin bad++; $display("FAIL unm_apb_count got=%0d exp=0", apb_q.size()); end

        // Window edges mixed with unmapped traffic.
        add(2'b10, 32'h9000_0000, 1'b0, 1'b1, 32'h0);
        add(2'b10, 32'h7FFF_FFFC, 1'b1, 1'b1, 32'h1111_2222);
        add(2'b10, 32'h8FFF_FFFC, 1'b0, 1'b1, 32'h0);
        add(2'b11, 32'h8000_0000, 1'b1, 1'b1, 32'h3333_4444);
        add(2'b10, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h5555_6666);
        run_seq("edge");
    endtask

    task automatic test_random();
        int          r, t;
        logic [31:0] a;
        logic [1:0]  tr;
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 30; i++) begin
                r = int'($urandom_range(0, 11));
                if (r <= 6)       a = 32'h8000_0000 + ($urandom_range(0, 3) << 26) + ($urandom & 32'h03FF_FFFC);
                else if (r == 7)  a = $urandom | 32'h9000_0000;
                else if (r == 8)  a = $urandom & 32'h7FFF_FFFC;
                else if (r == 9)  a = 32'h8FFF_FFFC;
                else if (r == 10) a = 32'h8000_0000;
                else              a = 32'h7FFF_FFFC;
                t = int'($urandom_range(0, 9));
                if (t == 0)      tr = 2'b00;
                else if (t == 1) tr = 2'b01;
                else             tr = {1'b1, 1'($urandom & 1)};
                add(tr, a, 1'($urandom & 1), ($urandom_range(0, 9) != 0), $urandom);
            end
            run_seq($sformatf("rnd%0d", round));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Hreset   = 1'b1;
        Hwdata   = 32'h0;
        idle_drive();
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_ignored();
        test_unmapped();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
- Synthesizable AHB-Lite slave to APB master bridge: the design-under-test that the bridge VIP interface drives on its AHB side and observes on its APB side.
- Accepts single AHB transfers and decodes each address to one of four APB slave selects.
- Runs one APB SETUP/ACCESS transfer per AHB transfer.
- Stretches the AHB data phase with Hreadyout until the APB access completes.

Parameters:
- ADDR_WIDTH, 32, address width on both AHB and APB sides.
- DATA_WIDTH, 32, data width on both sides.
- SLV_BASE, 32'h8000_0000, base address of APB slave 0.
- REGION_BITS, 26, log2 of the size of each slave region (64 MB).

Ports:
- Hclk in 1: single bridge clock, rising edge.
- Hreset in 1: synchronous, active-high reset.
- Htrans in 2: AHB transfer type; 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- Hsize in 3: transfer size; only 3'b010 is supported, and the value is not forwarded.
- Hreadyin in 1: AHB bus ready.
- Hwrite in 1: 1 = write.
- Haddr in ADDR_WIDTH: AHB address.
- Hwdata in DATA_WIDTH: write data, valid in the data phase.
- Hrdata out DATA_WIDTH: read data to AHB.
- Hresp out 2: 00 OKAY, 01 ERROR.
- Hreadyout out 1: bridge ready / end of data phase.
- Pselx out 4: one-hot APB slave select.
- Pwrite out 1: APB direction.
- Penable out 1: APB access phase.
- Paddr out ADDR_WIDTH: APB address.
- Pwdata out DATA_WIDTH: APB write data.
- Prdata in DATA_WIDTH: APB read data.

Behaviour:
- Reset: synchronous, active-high on Hreset. Next edge gives state IDLE and these output values:
  - Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0.
  - Hreadyout=1, Hresp=00, Hrdata=0.
- Reset mid-transfer abandons the APB transfer immediately. No completion is signalled.
- Valid transfer: Hreadyin=1, Htrans is 2 or 3, and Haddr falls in [SLV_BASE, SLV_BASE + 4*2^REGION_BITS).
  - Index = Haddr[REGION_BITS+1:REGION_BITS] relative to SLV_BASE.
  - IDLE or BUSY, or Hreadyin=0, is never valid.
- Sampling points: the address phase is sampled only in IDLE, RACC and WACC. On a valid transfer the bridge registers Haddr, Hwrite and the decoded select.
- States (Pselx/Penable/Pwrite/Paddr/Pwdata are registered; Hreadyout/Hrdata/Hresp are decoded from state):
  - IDLE:
    - Outputs: Hreadyout=1, Pselx=0, Penable=0.
    - Transitions: valid read -> RSETUP; valid write -> WWAIT.
  - WWAIT:
    - Outputs: Hreadyout=0; APB idle.
    - Captures Hwdata into Pwdata. Next state -> WSETUP.
  - RSETUP:
    - Outputs: Pselx=sel, Pwrite=0, Paddr=latched address, Penable=0, Hreadyout=0.
    - Next state -> RACC.
  - RACC:
    - Outputs: Penable=1, Hreadyout=1, Hrdata=Prdata (combinational pass-through).
    - Transitions: valid read -> RSETUP; valid write -> WWAIT; else IDLE.
  - WSETUP:
    - Outputs: Pselx=sel, Pwrite=1, Paddr, Pwdata held, Penable=0, Hreadyout=0.
    - Next state -> WACC.
  - WACC:
    - Outputs: Penable=1, Hreadyout=1.
    - Transitions: same as RACC.
- Latency, counted from the address-phase edge:
  - Read data phase: 2 cycles.
  - Write data phase: 3 cycles.
- Back-to-back transfers: consecutive transfers have no idle APB cycle between ACCESS and the next SETUP for reads. Writes insert WWAIT.
- Input handling while Hreadyout=0: AHB inputs are ignored apart from Hwdata in WWAIT. The master holds the next address.
- Output hold rules:
  - Pselx stays asserted from SETUP through ACCESS.
  - Pselx drops to 0 on return to IDLE.
  - Paddr and Pwrite hold their last values when idle.
- Hrdata is 0 outside RACC.
- Hresp is always 00 unless the optional feature is compiled in.
- Invalid address with the feature disabled: treated as no transfer, OKAY response, no APB activity.

Optional Feature:
- Macro: BRIDGE_ERR_RESP_EN.
- Defined:
  - A transfer with Hreadyin=1, Htrans NONSEQ/SEQ and an unmapped address enters ERR1, then ERR2.
  - ERR1: Hresp=01, Hreadyout=0.
  - ERR2: Hresp=01, Hreadyout=1. Address phase is sampled in ERR2 as in RACC.
  - No APB activity in either state.
- Undefined: the ERR states do not exist, and unmapped transfers are ignored as described above.

Test Plan:
- Reset: assert Hreset for 2 cycles mid-WSETUP -> next edge Pselx=0, Penable=0, Hreadyout=1, Hresp=00.
- Single write, Haddr=32'h8400_0010, Hwdata=32'hDEAD_BEEF -> WWAIT then Pselx=4'b0010, Pwrite=1, Paddr=32'h8400_0010, Pwdata=32'hDEAD_BEEF.
  - Penable=1 on the next cycle, together with Hreadyout=1.
- Single read at 32'h8C00_0004, slave drives Prdata=32'h1234_5678 -> Pselx=4'b1000 for 2 cycles; Hrdata=32'h1234_5678 while Hreadyout=1 in RACC.
- Back-to-back reads at 32'h8000_0000 and 32'h8800_0000 -> Pselx 0001 then 0100 with no IDLE cycle between; each data phase is 2 cycles.
- Htrans=BUSY or Hreadyin=0 with a mapped address -> Pselx stays 0 and Hreadyout stays 1.
- Unmapped address 32'h9000_0000 -> feature off: no APB activity, OKAY.
  - Feature on: Hresp=01 for 2 cycles, Hreadyout 0 then 1.
